// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register-file write port between pipeline writeback and a buffered long-latency unit
module regfile_wb_arbiter #(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_wb_valid,
  output logic        o_wb_ready,
  input  logic [4:0]  i_wb_rd_addr,
  input  logic [31:0] i_wb_rd_data,
  input  logic        i_lu_valid,
  output logic        o_lu_ready,
  input  logic [4:0]  i_lu_rd_addr,
  input  logic [31:0] i_lu_rd_data,
  input  logic        i_iss_valid,
  input  logic [4:0]  i_iss_rd_addr,
  input  logic [4:0]  i_chk_rs1_addr,
  input  logic [4:0]  i_chk_rs2_addr,
  input  logic [4:0]  i_chk_rd_addr,
  output logic        o_hazard_stall,
  output logic [4:0]  o_rd_addr,
  output logic [31:0] o_rd_data,
  output logic        o_rd_wren
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [4:0]    fifo_addr [FIFO_DEPTH];
  logic [31:0]   fifo_data [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [SW-1:0] starve_cnt;
  logic [31:0]   busy, busy_nxt;
  logic          empty, full, override, push, wb_grant, fifo_grant;
  logic [4:0]    head_addr, g_addr;
  logic [31:0]   head_data, g_data;
  assign empty      = count == '0;
  assign full       = count == CW'(FIFO_DEPTH);
  assign override   = !empty && starve_cnt == SW'(STARVE_LIMIT);
  assign o_wb_ready = !i_rst && !override;
  assign o_lu_ready = !i_rst && !full;
  assign push       = i_lu_valid && o_lu_ready;
  assign wb_grant   = i_wb_valid && o_wb_ready;
  assign fifo_grant = !i_rst && !empty && (override || !i_wb_valid);
  assign head_addr  = fifo_addr[rd_ptr];
  assign head_data  = fifo_data[rd_ptr];
  assign g_addr     = fifo_grant ? head_addr : i_wb_rd_addr;
  assign g_data     = fifo_grant ? head_data : i_wb_rd_data;
  assign o_hazard_stall = !i_rst && (busy[i_chk_rs1_addr] | busy[i_chk_rs2_addr] | busy[i_chk_rd_addr]);
  // set is applied after clear so a same-cycle issue to the retiring register stays busy
  always_comb begin
    busy_nxt = busy;
    if (fifo_grant) busy_nxt[head_addr] = 1'b0;
    if (i_iss_valid) busy_nxt[i_iss_rd_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
  end
  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= i_lu_rd_addr;
      fifo_data[wr_ptr] <= i_lu_rd_data;
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      starve_cnt <= '0;
      busy       <= '0;
      o_rd_addr  <= '0;
      o_rd_data  <= '0;
      o_rd_wren  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (fifo_grant) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(fifo_grant);
      starve_cnt <= (fifo_grant || empty) ? '0 :
                    (starve_cnt == SW'(STARVE_LIMIT)) ? starve_cnt : starve_cnt + SW'(1);
      busy <= busy_nxt;
      o_rd_wren <= (fifo_grant || wb_grant) && g_addr != '0;
      if (fifo_grant || wb_grant) begin
        o_rd_addr <= g_addr;
        o_rd_data <= g_data;
      end
    end
  end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port between two sources: the in-order pipeline writeback (WB) and a long-latency unit (LU, e.g. load/mul-div) that completes out of band.
- Buffers LU results in a small FIFO and arbitrates them against WB with bounded starvation.
- Keeps a per-register busy scoreboard for outstanding LU destinations and drives a hazard stall to decode.
- Sits between the writeback stage / LU and the register file write port (rd addr/data/wren).

Parameters:
- FIFO_DEPTH, 2, number of LU result entries buffered (power of 2, ≥2).
- STARVE_LIMIT, 4, consecutive cycles a non-empty FIFO may lose arbitration before WB is back-pressured (≥1).

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst  in  1  reset, synchronous, active-high.
- i_wb_valid  in  1  WB result valid.
- o_wb_ready  out  1  WB result accepted this cycle; WB holds its data while low.
- i_wb_rd_addr  in  5  WB destination register.
- i_wb_rd_data  in  32  WB result.
- i_lu_valid  in  1  LU result valid.
- o_lu_ready  out  1  FIFO can accept an LU result.
- i_lu_rd_addr  in  5  LU destination register.
- i_lu_rd_data  in  32  LU result.
- i_iss_valid  in  1  long-latency op issued this cycle.
- i_iss_rd_addr  in  5  destination of the issued op.
- i_chk_rs1_addr  in  5  decode source 1 to check.
- i_chk_rs2_addr  in  5  decode source 2 to check.
- i_chk_rd_addr  in  5  decode destination to check (WAW).
- o_hazard_stall  out  1  decode operand or destination is busy.
- o_rd_addr  out  5  register-file write address.
- o_rd_data  out  32  register-file write data.
- o_rd_wren  out  1  register-file write enable.

Behaviour:
- Reset: the clock and reset interface is one clock with a synchronous, active-high reset. On a clock edge with i_rst high, the FIFO is emptied, all scoreboard bits are cleared, the starve counter is set to 0, and o_rd_addr, o_rd_data and o_rd_wren are set to 0. While i_rst is high, o_lu_ready=0, o_wb_ready=0 and o_hazard_stall=0. A reset mid-operation discards all buffered LU results.
- Write port: o_rd_* are registered, giving 1 cycle of latency from grant to o_rd_wren. When nothing is granted, o_rd_wren=0 and o_rd_addr and o_rd_data hold their previous values.
- A granted entry whose rd is 0 is consumed with o_rd_wren=0.
- Arbitration, evaluated each cycle (override = FIFO non-empty and starve_cnt==STARVE_LIMIT):
  - If override: grant the FIFO head; o_wb_ready=0.
  - Else if i_wb_valid: grant WB; o_wb_ready=1.
  - Else if the FIFO is non-empty: grant the FIFO head.
  - o_wb_ready = !override (outside reset).
  - WB transfer happens when i_wb_valid && o_wb_ready.
- Starve counter:
  - Cleared to 0 when the FIFO is granted or empty.
  - Otherwise increments, saturating at STARVE_LIMIT.
  - When WB has no valid result, the FIFO is served without waiting for the counter.
- FIFO:
  - o_lu_ready = !full.
  - Push on i_lu_valid && o_lu_ready.
  - Pop on FIFO grant.
  - No same-cycle bypass: an entry pushed at edge N is first eligible in the cycle after N.
  - When not full, push and pop in the same cycle are both performed and the count is unchanged.
  - When full, ready stays low even if a pop occurs that cycle.
  - Pointers wrap modulo FIFO_DEPTH.
- Scoreboard (32 busy bits, bit 0 hard-wired to 0):
  - Set at the edge where i_iss_valid is high and i_iss_rd_addr!=0.
  - Cleared at the edge where a FIFO entry with that rd is granted.
  - Same-cycle set and clear on the same register: set wins.
  - o_hazard_stall = busy[rs1] | busy[rs2] | busy[rd], combinational.
  - Issuing to a busy rd is illegal; it is prevented by the rd term of o_hazard_stall.
- Busy clears at the grant edge and o_rd_wren rises at that same edge. A dependent instruction released the next cycle reads the value through the register file's same-cycle write bypass.

Test Plan:
- Reset, then idle -> o_rd_wren=0, o_lu_ready=1, o_wb_ready=1, o_hazard_stall=0.
- WB valid rd=5, data=0xA5A5_0001, FIFO empty -> o_rd_wren=1, o_rd_addr=5, o_rd_data=0xA5A5_0001 one cycle later. Then WB rd=0 -> o_rd_wren=0.
- Issue rd=7, then decode checks rs1=7 -> o_hazard_stall=1. LU returns rd=7, data=0x1234 with WB idle -> write to x7 two cycles after the push, and o_hazard_stall=0 in the cycle after grant.
- WB valid every cycle and one LU push (rd=3) -> after STARVE_LIMIT=4 lost cycles, o_wb_ready=0 for exactly one cycle, x3 is written, and WB resumes the next cycle with its held data written.
- Two LU pushes (rd=8, rd=9) while WB is busy -> o_lu_ready=0 when the FIFO is full. Then the pops occur in order, x8 before x9.
- Assert i_rst while the FIFO holds 2 entries and x8 is busy -> after reset there are no writes of the stale entries and o_hazard_stall=0 for rs1=8.
